sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock, parameterised first-in-first-out buffer with full and empty status flags.
- Used as an elastic buffer between producer and consumer stages of the CNN accelerator datapath running in the same clock domain.
- Write and read requests are qualified internally against the flags, so a caller cannot overflow or underflow the block.

Parameters:
- Width, 8, bit width of each data word.
- Depth, 8, number of storage entries; must be a power of two and at least 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- nrst_i  input  1  asynchronous active-low reset.
- write_i  input  1  write request; w_data_i is stored on the edge when the request is accepted.
- w_data_i  input  Width  write data.
- read_i  input  1  read request.
- r_data_o  output  Width  read data, registered.
- full_flag_o  output  1  high when Depth entries are stored.
- empty_flag_o  output  1  high when no entries are stored.

Behaviour:
- Reset (nrst_i low, asynchronous, no clock needed):
  - write and read pointers = 0
  - r_data_o = 0
  - empty_flag_o = 1, full_flag_o = 0
  - storage array is not reset.
- Pointers:
  - Write and read pointers are each log2(Depth)+1 bits; the MSB is the wrap bit.
  - Low bits address the storage.
  - Pointers increment modulo 2*Depth.
- Flags are decoded only from the registered pointers (no input-to-flag combinational path):
  - empty_flag_o = (wr_ptr == rd_ptr)
  - full_flag_o = low bits equal and wrap bits differ.
- Write:
  - Accepted when write_i=1 and full_flag_o=0.
  - On the edge, mem[wr_ptr low bits] <= w_data_i and wr_ptr increments.
  - Write while full is ignored: no pointer change, no memory change.
- Read:
  - Accepted when read_i=1 and empty_flag_o=0.
  - On the edge, r_data_o <= mem[rd_ptr low bits] and rd_ptr increments.
  - Data is valid on r_data_o one cycle after the accepted read request (1-cycle latency).
  - r_data_o holds its last value when no read is accepted.
  - Read while empty is ignored: r_data_o and pointers unchanged.
- Simultaneous write_i and read_i:
  - Neither full nor empty: both are accepted and occupancy is unchanged.
  - Full: read is accepted, write is rejected (flags are evaluated before the edge).
  - Empty: write is accepted, read is rejected; the newly written word is not bypassed to r_data_o.
- Flag timing:
  - empty_flag_o falls the cycle after the first accepted write.
  - full_flag_o rises the cycle after the Depth-th outstanding write.
- Wrap-around: continuous operation past 2*Depth writes must preserve FIFO order.
- Reset mid-operation: contents are discarded logically; the FIFO is empty after reset is released.
- No X may appear on any output after reset.

Decomposition:
- No shared package is required; Width and Depth are module parameters, and the pointer width is a derived localparam, $clog2(Depth)+1.
- One sub-module: sync_fifo_mem, a Depth x Width register array with one write port and one registered read port, instantiated by sync_fifo.
- Pointer and flag logic stays in the top module.

Test Plan:
- Reset then idle: nrst_i low for 1 cycle, then high with no requests -> empty_flag_o=1, full_flag_o=0, r_data_o=0.
- Fill: write 1..8 on 8 consecutive cycles -> empty_flag_o=0 after the 1st write, full_flag_o=1 after the 8th. A 9th write of 200 is ignored, and full_flag_o stays 1.
- Drain: from full, assert read_i for 8 cycles -> r_data_o = 1,2,...,8 on successive cycles, empty_flag_o=1 after the 8th read. A 9th read leaves r_data_o=8.
- Constant-data stress: write_i=1 with w_data_i=200 for 50 cycles, then write_i=0 and read_i=1 -> full after 8 writes, exactly 8 reads return 200, then empty_flag_o=1 and r_data_o holds 200.
- Simultaneous access with 4 entries stored: read_i=write_i=1 for 20 cycles with incrementing data -> flags constant, output order matches input order across pointer wrap.
- Boundaries:
  - Full plus simultaneous read/write -> one read accepted, write dropped, full_flag_o=0 next cycle.
  - Empty plus simultaneous read/write -> r_data_o unchanged, empty_flag_o=0 next cycle.
  - Asserting nrst_i mid-stream -> immediate empty_flag_o=1 and r_data_o=0.

Source files
------------

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one write port and one registered read port.
// The array itself is never reset. Only the read data register is reset.
module sync_fifo_mem #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] r_mem [Depth];
    logic [Width-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Holds the last word read while no read is accepted.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             write_i,
    input  logic [Width-1:0] w_data_i,
    input  logic             read_i,
    output logic [Width-1:0] r_data_o,
    output logic             full_flag_o,
    output logic             empty_flag_o
);

    localparam int unsigned PtrW  = $clog2(Depth) + 1;
    localparam int unsigned AddrW = PtrW - 1;

    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_en;
    logic            w_rd_en;

    // Flags come from the registered pointers only, so requests cannot reach the flags.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]) &&
                     (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]);

    assign w_wr_en = write_i && !w_full;
    assign w_rd_en = read_i && !w_empty;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    sync_fifo_mem #(
        .Width (Width),
        .Depth (Depth),
        .AddrW (AddrW)
    ) u_mem (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .we_i    (w_wr_en),
        .waddr_i (r_wr_ptr[AddrW-1:0]),
        .wdata_i (w_data_i),
        .re_i    (w_rd_en),
        .raddr_i (r_rd_ptr[AddrW-1:0]),
        .rdata_o (r_data_o)
    );

    assign full_flag_o  = w_full;
    assign empty_flag_o = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (Width=8, Depth=8) with hand-computed expectations.
module tb_sync_fifo;

    logic       clk_i = 1'b0;
    logic       nrst_i;
    logic       write_i;
    logic [7:0] w_data_i;
    logic       read_i;
    logic [7:0] r_data_o;
    logic       full_flag_o;
    logic       empty_flag_o;

    int total = 0;
    int bad   = 0;

    sync_fifo #(
        .Width (8),
        .Depth (8)
    ) dut (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .write_i      (write_i),
        .w_data_i     (w_data_i),
        .read_i       (read_i),
        .r_data_o     (r_data_o),
        .full_flag_o  (full_flag_o),
        .empty_flag_o (empty_flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] d, input logic e, input logic f);
        chk({tag, ".rdata"}, {24'd0, r_data_o}, {24'd0, d});
        chk({tag, ".empty"}, {31'd0, empty_flag_o}, {31'd0, e});
        chk({tag, ".full"}, {31'd0, full_flag_o}, {31'd0, f});
    endtask

    initial begin
        nrst_i   = 1'b0;
        write_i  = 1'b0;
        read_i   = 1'b0;
        w_data_i = 8'd0;

        // Reset then idle
        step();
        chk_state("reset", 8'd0, 1'b1, 1'b0);
        nrst_i = 1'b1;
        step();
        chk_state("idle", 8'd0, 1'b1, 1'b0);

        // Fill with 1..8
        write_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            w_data_i = 8'(i);
            step();
            if (i == 1) chk("fill.empty_after_1", {31'd0, empty_flag_o}, 32'd0);
            if (i == 7) chk("fill.full_after_7", {31'd0, full_flag_o}, 32'd0);
        end
        chk("fill.full_after_8", {31'd0, full_flag_o}, 32'd1);
        w_data_i = 8'd200;
        step();
        chk("fill.full_after_9th", {31'd0, full_flag_o}, 32'd1);
        write_i = 1'b0;

        // Drain from full
        read_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("drain.rdata", {24'd0, r_data_o}, 32'(i));
        end
        chk("drain.empty", {31'd0, empty_flag_o}, 32'd1);
        step();
        chk_state("drain.9th", 8'd8, 1'b1, 1'b0);
        read_i = 1'b0;

        // Constant-data stress
        write_i  = 1'b1;
        w_data_i = 8'd200;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (i == 7) chk("stress.full_after_7", {31'd0, full_flag_o}, 32'd0);
            if (i == 8) chk("stress.full_after_8", {31'd0, full_flag_o}, 32'd1);
        end
        chk("stress.full_after_50", {31'd0, full_flag_o}, 32'd1);
        write_i = 1'b0;
        read_i  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("stress.rdata", {24'd0, r_data_o}, 32'd200);
            if (i == 7) chk("stress.empty_after_7", {31'd0, empty_flag_o}, 32'd0);
        end
        step();
        chk_state("stress.drained", 8'd200, 1'b1, 1'b0);
        read_i = 1'b0;

        // Four stored, then 20 cycles of simultaneous read/write across wrap
        write_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data_i = 8'(10 + i);
            step();
        end
        read_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            w_data_i = 8'(14 + k);
            step();
            chk_state("simul", 8'(10 + k), 1'b0, 1'b0);
        end
        read_i = 1'b0;

        // Full plus simultaneous access: read wins, write dropped
        for (int i = 0; i < 4; i++) begin
            w_data_i = 8'(40 + i);
            step();
        end
        write_i = 1'b0;
        chk("bfull.full", {31'd0, full_flag_o}, 32'd1);
        write_i  = 1'b1;
        read_i   = 1'b1;
        w_data_i = 8'd99;
        step();
        chk_state("bfull.rw", 8'd30, 1'b0, 1'b0);
        write_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("bfull.drain", {24'd0, r_data_o}, (i < 3) ? 32'(31 + i) : 32'(40 + i - 3));
        end
        chk("bfull.empty", {31'd0, empty_flag_o}, 32'd1);
        read_i = 1'b0;

        // Empty plus simultaneous access: write wins, no bypass
        write_i  = 1'b1;
        read_i   = 1'b1;
        w_data_i = 8'd77;
        step();
        chk_state("bempty.rw", 8'd43, 1'b0, 1'b0);
        write_i = 1'b0;
        step();
        chk_state("bempty.read", 8'd77, 1'b1, 1'b0);
        read_i = 1'b0;

        // Mid-stream asynchronous reset
        write_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data_i = 8'(5 + i);
            step();
        end
        write_i = 1'b0;
        read_i  = 1'b1;
        step();
        chk("mid.rdata_before", {24'd0, r_data_o}, 32'd5);
        read_i = 1'b0;
        #3;
        nrst_i = 1'b0;
        #1;
        chk_state("mid.async", 8'd0, 1'b1, 1'b0);
        step();
        nrst_i = 1'b1;
        step();
        chk_state("mid.released", 8'd0, 1'b1, 1'b0);
        write_i  = 1'b1;
        w_data_i = 8'd9;
        step();
        write_i = 1'b0;
        read_i  = 1'b1;
        step();
        chk_state("mid.fresh", 8'd9, 1'b1, 1'b0);
        read_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
